vga_video_memory: RTL
=====================

// Module: vga_video_memory
//
// PURPOSE
//  Video memory that feeds the VGA controller's pixel fetch port (VGA_ADDR -> VGA_DATA).
//  Read side: 1-cycle registered read, always served, never stalled.
//  Write side: CPU/system writes arrive via a valid/ready port into a small FIFO, drained 1 word/cycle.
//  A hardware fill engine clears the whole screen to a single colour.
//
// PARAMETERS
//  ADDR_W      14             word address width; must match VGA_ADDR
//  DATA_W      15             block colour width; must match VGA_DATA
//  MEM_WORDS   2**ADDR_W      number of words; fill sweeps 0..MEM_WORDS-1
//  FIFO_DEPTH  4              write FIFO entries; power of two, >=2
//
// PORTS
//  PIXEL_CLK   in   1            pixel clock; the only clock
//  RESET_N     in   1            asynchronous, active-low reset
//  VGA_ADDR    in   ADDR_W       pixel-fetch address from the VGA controller
//  VGA_DATA    out  DATA_W       colour word for the VGA_ADDR of the previous cycle
//  WR_VALID    in   1            write request
//  WR_READY    out  1            write accepted when WR_VALID & WR_READY
//  WR_ADDR     in   ADDR_W       write address
//  WR_DATA     in   DATA_W       write data
//  FILL_START  in   1            1-cycle pulse: request a full-screen fill
//  FILL_COLOR  in   DATA_W       fill colour; sampled on the cycle FILL_START is accepted
//  FILL_BUSY   out  1            high from fill acceptance until the last fill word is written
//  FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//
// BEHAVIOUR
//  Reset (async assert, sync release): VGA_DATA=0, WR_READY=0, FILL_BUSY=0, FIFO_LEVEL=0.
//   FSM goes to IDLE. RAM contents are not cleared.
//   WR_READY may rise on the first clock edge after RESET_N deasserts.
//  Read: VGA_DATA <= mem[VGA_ADDR] every cycle (latency 1), independent of writes and fill.
//  RAM write port: one write/cycle. Priority is fill engine first, then FIFO head.
//  FIFO:
//   - WR_READY = !full & (state==IDLE).
//   - Push on WR_VALID&WR_READY. Pop when not empty and state!=FILL.
//   - Simultaneous push+pop when full is impossible, because WR_READY=0 when full.
//   - Push+pop in the same cycle keeps the level unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Write visibility: a word accepted in cycle t is written to RAM at edge t+1.
//   A VGA read presented in cycle t+2 or later returns it.
//  FSM: IDLE, DRAIN, FILL.
//   - IDLE --FILL_START & FIFO empty--> FILL. Latch FILL_COLOR, fill_addr=0, FILL_BUSY=1.
//   - IDLE --FILL_START & FIFO non-empty--> DRAIN. Latch FILL_COLOR, FILL_BUSY=1, no new pushes.
//   - DRAIN --FIFO empty--> FILL with fill_addr=0.
//   - FILL: write FILL_COLOR to mem[fill_addr] and increment fill_addr.
//     At fill_addr==MEM_WORDS-1, write that word, then go to IDLE and drop FILL_BUSY the next cycle.
//   - Fill duration: exactly MEM_WORDS cycles in FILL.
//   - FILL_START while FILL_BUSY=1 is ignored (not queued).
//   - FILL_START and WR_VALID in the same IDLE cycle: the write is accepted first, so the FSM enters DRAIN.
//  Reset mid-fill or mid-drain: aborts immediately; FIFO contents are discarded; memory is left partially written.
//  Addresses >= MEM_WORDS (when MEM_WORDS < 2**ADDR_W): writes are dropped, reads return 0.
//
// CONFIGURATION
//  VGA_MEM_WR_BYPASS_EN:
//   - Defined: if VGA_ADDR equals the RAM write address in the same cycle (FIFO pop or fill),
//     VGA_DATA next cycle = the data being written (write-first).
//   - Undefined: same-address collision returns the old RAM word (read-first); the new value appears on the next read.
//
// TESTING
//  1. Reset, then WR 0x0005<-0x7FFF in cycle t; VGA_ADDR=0x0005 at t+2 -> VGA_DATA=0x7FFF at t+3.
//  2. Push 4 words back-to-back with no drain stall -> FIFO_LEVEL never >2; WR_READY stays 1; all 4 read back.
//  3. Enqueue 3 words, then FILL_START with FILL_COLOR=0x001F in the same cycle -> DRAIN, 3 pops, then 16384 fill cycles.
//     FILL_BUSY deasserts; every address reads 0x001F.
//  4. FILL_START pulsed again mid-fill -> ignored; total busy = drain cycles + 16384; WR_READY=0 throughout.
//  5. VGA_ADDR=0x0100 while the FIFO pops a write to 0x0100 (old 0x1111, new 0x2222).
//     With _EN -> 0x2222; without -> 0x1111, then 0x2222 on the next read.
//  6. Assert RESET_N=0 at fill_addr=0x0800 -> FILL_BUSY=0 and WR_READY=0 immediately.
//     After release: addr 0x07FF holds the fill colour, 0x0800 keeps its old value.

Source files
------------

// File: rtl/vga_video_memory_if.sv
// -----------------------------------------------------------------------------
// vga_video_memory_if
//
// Purpose:
//   Groups the pixel-fetch, write, fill and status signals of vga_video_memory
//   into one bundle. The signal names match the memory's documented port names.
//
// Signals (slave = memory side):
//   VGA_ADDR   in   ADDR_W  pixel-fetch address
//   VGA_DATA   out  DATA_W  colour word for the previous cycle's VGA_ADDR
//   WR_VALID   in   1       write request
//   WR_READY   out  1       write accepted when WR_VALID & WR_READY
//   WR_ADDR    in   ADDR_W  write address
//   WR_DATA    in   DATA_W  write data
//   FILL_START in   1       one-cycle pulse requesting a full-screen fill
//   FILL_COLOR in   DATA_W  fill colour, sampled when FILL_START is accepted
//   FILL_BUSY  out  1       high from fill acceptance until last fill word written
//   FIFO_LEVEL out  LVL_W   write FIFO occupancy
//   DBG_STATE  out  2       controller state (0 IDLE, 1 DRAIN, 2 FILL)
//
// Handshake: a write transfers on every rising clock edge where WR_VALID and
// WR_READY are both high. WR_READY never depends on WR_VALID.
// -----------------------------------------------------------------------------
interface vga_video_memory_if #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 15,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] VGA_ADDR;
  logic [DATA_W-1:0] VGA_DATA;
  logic              WR_VALID;
  logic              WR_READY;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic              FILL_START;
  logic [DATA_W-1:0] FILL_COLOR;
  logic              FILL_BUSY;
  logic [LVL_W-1:0]  FIFO_LEVEL;
  logic [1:0]        DBG_STATE;

  modport master (
    output VGA_ADDR, WR_VALID, WR_ADDR, WR_DATA, FILL_START, FILL_COLOR,
    input  VGA_DATA, WR_READY, FILL_BUSY, FIFO_LEVEL, DBG_STATE
  );

  modport slave (
    input  VGA_ADDR, WR_VALID, WR_ADDR, WR_DATA, FILL_START, FILL_COLOR,
    output VGA_DATA, WR_READY, FILL_BUSY, FIFO_LEVEL, DBG_STATE
  );
endinterface

// File: rtl/vga_video_memory.sv
// -----------------------------------------------------------------------------
// vga_video_memory
//
// Purpose:
//   Video RAM behind the VGA pixel-fetch port. Reads are registered (latency 1)
//   and never stall. System writes enter a small FIFO that drains one word per
//   cycle into the single RAM write port. A fill engine overwrites every word
//   with one colour; it first drains pending FIFO writes, then sweeps
//   0..MEM_WORDS-1, one word per cycle.
//
// Ports:
//   PIXEL_CLK  in  pixel clock (only clock)
//   RESET_N    in  asynchronous active-low reset, synchronous release
//   bus        vga_video_memory_if.slave (pixel fetch, write port, fill, status)
//
// Configuration macro:
//   VGA_MEM_WR_BYPASS_EN  defined: a read that hits the address being written
//                         in the same cycle returns the new data (write-first).
//                         undefined: such a read returns the old word.
// -----------------------------------------------------------------------------
module vga_video_memory #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 15,
  parameter int MEM_WORDS  = 2**ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PIXEL_CLK,
  input  logic              RESET_N,
  vga_video_memory_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W:0]   MEM_WORDS_W = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_FILL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_color_q, fill_color_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              rdy_en_q;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic [ENT_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_q  [MEM_WORDS];

  logic              fifo_empty, fifo_full, wr_ready, push, pop;
  logic [ENT_W-1:0]  head;
  logic              ram_we, ram_we_ok;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == LVL_W'(FIFO_DEPTH));
  // rdy_en_q keeps WR_READY low during reset and releases it on the first edge after.
  assign wr_ready   = rdy_en_q & ~fifo_full & (state_q == S_IDLE);
  assign push       = bus.WR_VALID & wr_ready;
  assign pop        = ~fifo_empty & (state_q != S_FILL);
  assign head       = fifo_q[rd_ptr_q];

  // Single RAM write port: the fill engine owns it while in FILL, otherwise the FIFO head.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = head[ENT_W-1:DATA_W];
    ram_data = head[DATA_W-1:0];
    if (state_q == S_FILL) begin
      ram_we   = 1'b1;
      ram_addr = fill_addr_q;
      ram_data = fill_color_q;
    end else if (pop) begin
      ram_we = 1'b1;
    end
  end

  // Writes outside the populated range are dropped.
  assign ram_we_ok = ram_we & ({1'b0, ram_addr} < MEM_WORDS_W);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Controller: a fill request accepted together with a write (or with words
  // still queued) drains the FIFO first so no older write lands after the fill.
  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_color_d = fill_color_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.FILL_START) begin
          fill_color_d = bus.FILL_COLOR;
          fill_addr_d  = '0;
          state_d      = (!fifo_empty || push) ? S_DRAIN : S_FILL;
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          fill_addr_d = '0;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        fill_addr_d = fill_addr_q + ADDR_W'(1);
        if (fill_addr_q == LAST_ADDR) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vga_data_d = '0;
    if ({1'b0, bus.VGA_ADDR} < MEM_WORDS_W) vga_data_d = mem_q[bus.VGA_ADDR];
`ifdef VGA_MEM_WR_BYPASS_EN
    if (ram_we_ok && (ram_addr == bus.VGA_ADDR)) vga_data_d = ram_data;
`else
`endif
  end

  always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      fill_addr_q  <= '0;
      fill_color_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rdy_en_q     <= 1'b0;
      vga_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      fill_color_q <= fill_color_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q      <= count_d;
      rdy_en_q     <= 1'b1;
      vga_data_q   <= vga_data_d;
    end
  end

  // Storage arrays carry no reset: RAM contents survive reset, and stale FIFO
  // entries are unreachable once the pointers and count are cleared.
  always_ff @(posedge PIXEL_CLK) begin
    if (push) fifo_q[wr_ptr_q] <= {bus.WR_ADDR, bus.WR_DATA};
  end

  always_ff @(posedge PIXEL_CLK) begin
    if (ram_we_ok) mem_q[ram_addr] <= ram_data;
  end

  assign bus.VGA_DATA   = vga_data_q;
  assign bus.WR_READY   = wr_ready;
  assign bus.FILL_BUSY  = (state_q != S_IDLE);
  assign bus.FIFO_LEVEL = count_q;
  assign bus.DBG_STATE  = state_q;
endmodule
